coin_front_end: RTL and testbench
=================================

# coin_front_end

Input front end of the vending machine. It debounces the raw coin-sensor and selection-button lines and buffers accepted coins in a small FIFO. It then issues them to the vending-machine FSM as single-cycle `coin_in` / `button_in` codes, only while the FSM is idle. All coins are always delivered before a selection, so the FSM never sees a button before the full balance.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive identical raw samples required before a debounced line changes level (≥2).
- `FIFO_DEPTH`, 4: coin FIFO entries (power of two, ≥2).
- `GAP_CYCLES`, 2: forced idle cycles after every emitted code (≥1).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `coin_sense` in 5: raw coin sensors, one bit per coin: bit0=10c, bit1=20c, bit2=50c, bit3=1€, bit4=2€.
- `button_sense` in 2: raw buttons: bit0=water, bit1=soda.
- `vm_idle` in 1: FSM is in its coin/selection-accepting state; driven externally as `beverage_out==0 && change_out==0`.
- `coin_in` out 3: coin code to FSM: 0=none, 1=10c, 2=20c, 3=50c, 4=1€, 5=2€.
- `button_in` out 2: selection to FSM: 0=none, 1=water, 2=soda.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: coins currently buffered.
- `reject_out` out 1: one-cycle pulse per rejected coin. Present only with `COIN_FRONT_END_REJECT_EN`.

## Operation
- **Debounce:** each of the 7 raw lines has a counter. The debounced level flips after `DEBOUNCE_CYCLES` consecutive samples differing from the current level; any matching sample clears the counter. An event is the debounced 0→1 edge only.
- **Coin events:**
  - Exactly one coin edge in a cycle: the code is pushed to the FIFO.
  - Two or more coin edges in the same cycle: invalid, nothing pushed, counts as a reject.
  - Push when full: accepted only if a pop occurs in the same cycle. Otherwise the coin is rejected and FIFO contents are untouched (no overwrite).
- **Button events:** one pending-selection register.
  - A single button edge while nothing is pending sets it.
  - Both edges in the same cycle: ignored.
  - A further edge while a selection is pending: ignored (first wins).
- **Emit FSM**, states IDLE, EMIT, GAP:
  - IDLE → EMIT when `vm_idle`=1 and either the FIFO is non-empty (pop, drive code on `coin_in`) or, with the FIFO empty, a selection is pending (drive `button_in`, clear pending). Coins take priority.
  - EMIT lasts exactly 1 cycle → GAP.
  - GAP lasts `GAP_CYCLES` cycles, outputs 0 → IDLE.
  - `vm_idle` falling during EMIT or GAP does not abort; it is only sampled in IDLE.
- `coin_in` and `button_in` are never both non-zero.
- `fifo_level` counts 0..`FIFO_DEPTH`. Read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo depth.

## Timing
- All outputs are registered. Reset (`rst`=0) asynchronously clears:
  - `coin_in`, `button_in`, `fifo_level` and `reject_out` to 0;
  - FSM to IDLE, pending selection and debounced levels to 0.
- Reset mid-operation discards buffered coins and any pending selection.
- Raw coin rise to FIFO push: `DEBOUNCE_CYCLES`+1 cycles.
- Push to `coin_in` driven, with FIFO previously empty, `vm_idle`=1, FSM IDLE: 1 cycle.
- Back-to-back coins are emitted every 1+`GAP_CYCLES` cycles.
- `reject_out` is asserted the cycle after the offending event.

## Configuration
- `COIN_FRONT_END_REJECT_EN` defined: the `reject_out` port exists and drives the return flap on every rejected coin (multi-coin or FIFO full).
- Undefined: the port is absent and rejected coins are dropped silently; all other behaviour is identical.

## Structure
- `vm_pkg` holds:
  - `coin_code_t` enum (NONE, C10, C20, C50, E1, E2);
  - `button_code_t` enum (NONE, WATER, SODA);
  - `emit_state_t` (IDLE, EMIT, GAP);
  - the coin bit-to-code mapping constant.
- Sub-module `sensor_debounce`, parameterised by `DEBOUNCE_CYCLES`: one line in, debounced level plus rise pulse out. It is instantiated 7 times. The FIFO stays inline.

## Test plan
- 50c sensor high for 6 cycles, `vm_idle`=1 → exactly one `coin_in`=3 pulse, 6 cycles after the rise; `fifo_level` returns to 0.
- 3-cycle glitch on the 1€ line → no push, `coin_in` stays 0.
- `vm_idle`=0; insert 10c, 20c, 2€, then a soda press; raise `vm_idle` → `coin_in` 1, 2, 5, then `button_in`=2, each separated by `GAP_CYCLES` zero cycles.
- `vm_idle`=0; insert 5 coins with `FIFO_DEPTH`=4 → `fifo_level`=4 and the 5th is rejected (`reject_out` pulse when enabled); the first 4 codes are later emitted in order.
- 10c and 20c lines rising on the same cycle → nothing queued, one reject.
- `rst` asserted with 2 coins queued and water pending → all outputs 0 immediately; nothing is emitted after release.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared types for the vending-machine input path: coin/button codes, emit FSM states.
// Coin sensor bit i maps to COIN_MAP[i].
package vm_pkg;

  localparam int N_COINS   = 5;
  localparam int N_BUTTONS = 2;

  typedef enum logic [2:0] {
    COIN_NONE = 3'd0,
    C10       = 3'd1,
    C20       = 3'd2,
    C50       = 3'd3,
    E1        = 3'd4,
    E2        = 3'd5
  } coin_code_t;

  typedef enum logic [1:0] {
    BTN_NONE = 2'd0,
    WATER    = 2'd1,
    SODA     = 2'd2
  } button_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } emit_state_t;

  localparam coin_code_t COIN_MAP [N_COINS] = '{C10, C20, C50, E1, E2};

  // Code of the highest set sensor bit; callers guarantee at most one bit is set.
  function automatic coin_code_t coin_code(input logic [N_COINS-1:0] rise);
    coin_code_t code;
    code = COIN_NONE;
    for (int i = 0; i < N_COINS; i++) begin
      if (rise[i]) code = COIN_MAP[i];
    end
    return code;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Debounces one raw line; level flips after DEBOUNCE_CYCLES consecutive differing samples.
// Latency: rise pulses on the edge that flips the level (DEBOUNCE_CYCLES samples after the raw rise).
// No backpressure: rise is a single-cycle pulse.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      rise <= 1'b0;
      if (raw != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= raw;
          rise  <= raw;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/coin_front_end.sv
// Debounces coin/button sensors, queues coins, emits single-cycle codes to the FSM while it idles.
// Latency: raw rise to push DEBOUNCE_CYCLES+1, push to coin_in 1; codes spaced 1+GAP_CYCLES apart.
// Backpressure: vm_idle=0 holds codes; push into a full FIFO is rejected (reject_out with COIN_FRONT_END_REJECT_EN).
module coin_front_end #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [4:0]                   coin_sense,
  input  logic [1:0]                   button_sense,
  input  logic                         vm_idle,
  output logic [2:0]                   coin_in,
  output logic [1:0]                   button_in,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
`ifdef COIN_FRONT_END_REJECT_EN
  ,
  output logic                         reject_out
`endif
);

  import vm_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [N_COINS-1:0]   coin_lvl, coin_rise;
  logic [N_BUTTONS-1:0] btn_lvl, btn_rise;

  for (genvar i = 0; i < N_COINS; i++) begin : g_coin
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk), .rst(rst), .raw(coin_sense[i]), .level(coin_lvl[i]), .rise(coin_rise[i])
    );
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk), .rst(rst), .raw(button_sense[i]), .level(btn_lvl[i]), .rise(btn_rise[i])
    );
  end

  emit_state_t  state, state_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  button_code_t pend;
  coin_code_t   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  coin_code_t   coin_n;
  button_code_t btn_n;

  logic one_coin, full, push, pop, sel_take, grant;

  assign one_coin = (|coin_rise) && ((coin_rise & (coin_rise - 5'd1)) == '0);
  assign full     = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign grant    = (state == IDLE) && vm_idle;
  assign pop      = grant && (fifo_level != '0);
  assign sel_take = grant && (fifo_level == '0) && (pend != BTN_NONE);
  // A full FIFO still takes the coin when the same cycle frees a slot.
  assign push     = one_coin && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= coin_code(coin_rise);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // First selection wins; simultaneous presses are ambiguous and dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= BTN_NONE;
    end else if (sel_take) begin
      pend <= BTN_NONE;
    end else if (pend == BTN_NONE && btn_rise == 2'b01) begin
      pend <= WATER;
    end else if (pend == BTN_NONE && btn_rise == 2'b10) begin
      pend <= SODA;
    end
  end

`ifdef COIN_FRONT_END_REJECT_EN
  logic multi_coin;
  assign multi_coin = (|coin_rise) && !one_coin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) reject_out <= 1'b0;
    else      reject_out <= multi_coin || (one_coin && full && !pop);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      coin_in   <= '0;
      button_in <= '0;
    end else begin
      state     <= state_n;
      gap_cnt   <= gap_cnt_n;
      coin_in   <= coin_n;
      button_in <= btn_n;
    end
  end

  // The IDLE decision cycle is the last zero cycle, so GAP itself holds GAP_CYCLES-1 cycles.
  always_comb begin
    state_n   = state;
    gap_cnt_n = gap_cnt;
    case (state)
      IDLE: if (pop || sel_take) state_n = EMIT;
      EMIT: begin
        gap_cnt_n = '0;
        state_n   = (GAP_CYCLES > 1) ? GAP : IDLE;
      end
      GAP: begin
        if (int'(gap_cnt) >= GAP_CYCLES - 2) state_n = IDLE;
        else                                 gap_cnt_n = gap_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    coin_n = COIN_NONE;
    btn_n  = BTN_NONE;
    if (pop)           coin_n = fifo_mem[rd_ptr];
    else if (sel_take) btn_n  = pend;
  end

endmodule

// File: tb/tb_coin_front_end.sv
// Directed bench for coin_front_end with default parameters (debounce 4, depth 4, gap 2).
module tb_coin_front_end;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] coin_sense = '0;
  logic [1:0] button_sense = '0;
  logic       vm_idle = 1'b0;
  logic [2:0] coin_in;
  logic [1:0] button_in;
  logic [2:0] fifo_level;
`ifdef COIN_FRONT_END_REJECT_EN
  logic       reject_out;
`endif

  int total = 0;
  int bad = 0;
  int rej_seen = 0;

  coin_front_end dut (
    .clk(clk),
    .rst(rst),
    .coin_sense(coin_sense),
    .button_sense(button_sense),
    .vm_idle(vm_idle),
    .coin_in(coin_in),
    .button_in(button_in),
    .fifo_level(fifo_level)
`ifdef COIN_FRONT_END_REJECT_EN
    ,
    .reject_out(reject_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
`ifdef COIN_FRONT_END_REJECT_EN
    if (reject_out) rej_seen++;
`endif
  endtask

  task automatic insert_coin(input logic [4:0] m);
    coin_sense = m;
    repeat (6) step();
    coin_sense = '0;
    repeat (6) step();
  endtask

  task automatic press(input logic [1:0] m);
    button_sense = m;
    repeat (6) step();
    button_sense = '0;
    repeat (6) step();
  endtask

  task automatic test_reset();
    #2;
    total++; if (coin_in !== 3'd0) begin bad++; $display("FAIL reset_coin_in got=%0d exp=0", coin_in); end
    total++; if (button_in !== 2'd0) begin bad++; $display("FAIL reset_button_in got=%0d exp=0", button_in); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_fifo_level got=%0d exp=0", fifo_level); end
`ifdef COIN_FRONT_END_REJECT_EN
    total++; if (reject_out !== 1'b0) begin bad++; $display("FAIL reset_reject got=%0d exp=0", reject_out); end
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single_coin();
    logic [2:0] exp;
    vm_idle = 1'b1;
    coin_sense = 5'b00100;
    for (int k = 1; k <= 14; k++) begin
      step();
      exp = (k == 6) ? 3'd3 : 3'd0;
      total++; if (coin_in !== exp) begin bad++; $display("FAIL single_coin k=%0d got=%0d exp=%0d", k, coin_in, exp); end
      if (k == 5) begin
        total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL single_level_push got=%0d exp=1", fifo_level); end
      end
      if (k == 6) begin
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL single_level_pop got=%0d exp=0", fifo_level); end
        coin_sense = '0;
      end
    end
  endtask

  task automatic test_glitch();
    int nz = 0;
    coin_sense = 5'b01000;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) coin_sense = '0;
      if (coin_in != 3'd0 || fifo_level != 3'd0) nz++;
    end
    total++; if (nz !== 0) begin bad++; $display("FAIL glitch_activity got=%0d exp=0", nz); end
  endtask

  task automatic test_queue();
    logic [2:0] exp_c;
    logic [1:0] exp_b;
    vm_idle = 1'b0;
    insert_coin(5'b00001);
    insert_coin(5'b00010);
    insert_coin(5'b10000);
    press(2'b10);
    total++; if (fifo_level !== 3'd3) begin bad++; $display("FAIL queue_level got=%0d exp=3", fifo_level); end
    total++; if (coin_in !== 3'd0) begin bad++; $display("FAIL queue_held got=%0d exp=0", coin_in); end
    vm_idle = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      case (k)
        1: exp_c = 3'd1;
        4: exp_c = 3'd2;
        7: exp_c = 3'd5;
        default: exp_c = 3'd0;
      endcase
      exp_b = (k == 10) ? 2'd2 : 2'd0;
      total++; if (coin_in !== exp_c) begin bad++; $display("FAIL queue_coin k=%0d got=%0d exp=%0d", k, coin_in, exp_c); end
      total++; if (button_in !== exp_b) begin bad++; $display("FAIL queue_button k=%0d got=%0d exp=%0d", k, button_in, exp_b); end
    end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL queue_drained got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_overflow();
    logic [2:0] exp_c;
    vm_idle = 1'b0;
    rej_seen = 0;
    for (int i = 0; i < 5; i++) insert_coin(5'b00001 << i);
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL overflow_level got=%0d exp=4", fifo_level); end
`ifdef COIN_FRONT_END_REJECT_EN
    total++; if (rej_seen !== 1) begin bad++; $display("FAIL overflow_reject got=%0d exp=1", rej_seen); end
`endif
    vm_idle = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      case (k)
        1: exp_c = 3'd1;
        4: exp_c = 3'd2;
        7: exp_c = 3'd3;
        10: exp_c = 3'd4;
        default: exp_c = 3'd0;
      endcase
      total++; if (coin_in !== exp_c) begin bad++; $display("FAIL overflow_coin k=%0d got=%0d exp=%0d", k, coin_in, exp_c); end
    end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL overflow_drained got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_multi_coin();
    int nz = 0;
    vm_idle = 1'b1;
    rej_seen = 0;
    coin_sense = 5'b00011;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 6) coin_sense = '0;
      if (coin_in != 3'd0 || fifo_level != 3'd0) nz++;
    end
    total++; if (nz !== 0) begin bad++; $display("FAIL multi_activity got=%0d exp=0", nz); end
`ifdef COIN_FRONT_END_REJECT_EN
    total++; if (rej_seen !== 1) begin bad++; $display("FAIL multi_reject got=%0d exp=1", rej_seen); end
`endif
  endtask

  task automatic test_reset_mid();
    int nz = 0;
    vm_idle = 1'b0;
    insert_coin(5'b00100);
    insert_coin(5'b01000);
    press(2'b01);
    total++; if (fifo_level !== 3'd2) begin bad++; $display("FAIL rstmid_level got=%0d exp=2", fifo_level); end
    vm_idle = 1'b1;
    step();
    total++; if (coin_in !== 3'd3) begin bad++; $display("FAIL rstmid_first got=%0d exp=3", coin_in); end
    #3 rst = 1'b0;
    #1;
    total++; if (coin_in !== 3'd0) begin bad++; $display("FAIL rstmid_coin_in got=%0d exp=0", coin_in); end
    total++; if (button_in !== 2'd0) begin bad++; $display("FAIL rstmid_button_in got=%0d exp=0", button_in); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rstmid_fifo_level got=%0d exp=0", fifo_level); end
    repeat (2) step();
    rst = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (coin_in != 3'd0 || button_in != 2'd0 || fifo_level != 3'd0) nz++;
    end
    total++; if (nz !== 0) begin bad++; $display("FAIL rstmid_after got=%0d exp=0", nz); end
  endtask

  initial begin
    test_reset();
    test_single_coin();
    test_glitch();
    test_queue();
    test_overflow();
    test_multi_coin();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
